// File: rtl/tlc_conflict_monitor.sv
// Safety monitor between the traffic light controller and the lamp drivers.
// It passes legal light codes through and latches the first violation into an all-red flash.
module tlc_conflict_monitor #(
  parameter int unsigned MIN_GREEN  = 1,
  parameter int unsigned MIN_YELLOW = 1,
  parameter int unsigned MIN_ALLRED = 1,
  parameter int unsigned FLASH_HALF = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] hwy,
  input  logic [1:0] cntry,
  input  logic       fault_clr,
  output logic [1:0] hwy_lamp,
  output logic [1:0] cntry_lamp,
  output logic       fault,
  output logic [2:0] fault_code
);

  typedef enum logic {MON_PASS, MON_FLASH} monState_e;

  localparam logic [1:0] RED = 2'b00;
  localparam logic [1:0] YEL = 2'b01;
  localparam logic [1:0] GRN = 2'b10;
  localparam logic [1:0] BAD = 2'b11;

  localparam logic [2:0] CODE_ILLEGAL  = 3'd1;
  localparam logic [2:0] CODE_CONFLICT = 3'd2;
  localparam logic [2:0] CODE_BAD_SEQ  = 3'd3;
  localparam logic [2:0] CODE_SHORT_G  = 3'd4;
  localparam logic [2:0] CODE_SHORT_Y  = 3'd5;
  localparam logic [2:0] CODE_SHORT_AR = 3'd6;

  localparam logic [7:0] MIN_G8  = 8'(MIN_GREEN);
  localparam logic [7:0] MIN_Y8  = 8'(MIN_YELLOW);
  localparam logic [7:0] MIN_AR8 = 8'(MIN_ALLRED);
  localparam logic [8:0] FLASH_H9    = 9'(FLASH_HALF);
  localparam logic [8:0] FLASH_LAST9 = 9'(2 * FLASH_HALF - 1);

  monState_e  state_q, state_d;
  logic [2:0] code_q, code_d;
  logic [1:0] hLamp_q, hLamp_d, cLamp_q, cLamp_d;
  logic [1:0] prevH_q, prevH_d, prevC_q, prevC_d;
  logic       prevValid_q, prevValid_d;
  logic [7:0] dwellH_q, dwellH_d, dwellC_q, dwellC_d;
  logic [7:0] allRed_q, allRed_d;
  logic [8:0] flash_q, flash_d;
  logic [2:0] viol;

  function automatic logic [7:0] sat8(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  // Judges one road's code change against the legal cycle and the minimum holds.
  function automatic logic [2:0] roadViol(input logic [1:0] oldCode, input logic [1:0] newCode,
                                          input logic [7:0] dwell, input logic [7:0] allRed);
    logic [2:0] r;
    r = 3'd0;
    if (oldCode != newCode) begin
      if (oldCode == GRN && newCode == YEL)      r = (dwell < MIN_G8) ? CODE_SHORT_G : 3'd0;
      else if (oldCode == YEL && newCode == RED) r = (dwell < MIN_Y8) ? CODE_SHORT_Y : 3'd0;
      else if (oldCode == RED && newCode == GRN) r = (allRed < MIN_AR8) ? CODE_SHORT_AR : 3'd0;
      else                                       r = CODE_BAD_SEQ;
    end
    return r;
  endfunction

  function automatic logic [2:0] lowestOf(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] r;
    if (a == 3'd0)      r = b;
    else if (b == 3'd0) r = a;
    else                r = (a < b) ? a : b;
    return r;
  endfunction

  always_comb begin
    viol = 3'd0;
    if (hwy == BAD || cntry == BAD)
      viol = CODE_ILLEGAL;
    else if (hwy != RED && cntry != RED)
      viol = CODE_CONFLICT;
    else if (prevValid_q)
      viol = lowestOf(roadViol(prevH_q, hwy, dwellH_q, allRed_q),
                      roadViol(prevC_q, cntry, dwellC_q, allRed_q));
  end

  // In flash, a clear restarts monitoring from a fresh init sample.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    hLamp_d     = hLamp_q;
    cLamp_d     = cLamp_q;
    prevH_d     = prevH_q;
    prevC_d     = prevC_q;
    prevValid_d = prevValid_q;
    dwellH_d    = dwellH_q;
    dwellC_d    = dwellC_q;
    allRed_d    = allRed_q;
    flash_d     = flash_q;
    case (state_q)
      MON_PASS: begin
        if (viol != 3'd0) begin
          state_d = MON_FLASH;
          code_d  = viol;
          flash_d = 9'd0;
          hLamp_d = RED;
          cLamp_d = RED;
        end else begin
          hLamp_d     = hwy;
          cLamp_d     = cntry;
          dwellH_d    = (hwy != prevH_q) ? 8'd1 : sat8(dwellH_q);
          dwellC_d    = (cntry != prevC_q) ? 8'd1 : sat8(dwellC_q);
          allRed_d    = (hwy == RED && cntry == RED) ? sat8(allRed_q) : 8'd0;
          prevH_d     = hwy;
          prevC_d     = cntry;
          prevValid_d = 1'b1;
        end
      end
      MON_FLASH: begin
        if (fault_clr) begin
          state_d     = MON_PASS;
          code_d      = 3'd0;
          hLamp_d     = RED;
          cLamp_d     = RED;
          prevH_d     = RED;
          prevC_d     = RED;
          prevValid_d = 1'b0;
          dwellH_d    = 8'd0;
          dwellC_d    = 8'd0;
          allRed_d    = 8'd0;
          flash_d     = 9'd0;
        end else begin
          flash_d = (flash_q == FLASH_LAST9) ? 9'd0 : flash_q + 9'd1;
          hLamp_d = (flash_d < FLASH_H9) ? RED : BAD;
          cLamp_d = (flash_d < FLASH_H9) ? RED : BAD;
        end
      end
      default: state_d = MON_PASS;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= MON_PASS;
      code_q      <= 3'd0;
      hLamp_q     <= RED;
      cLamp_q     <= RED;
      prevH_q     <= RED;
      prevC_q     <= RED;
      prevValid_q <= 1'b0;
      dwellH_q    <= 8'd0;
      dwellC_q    <= 8'd0;
      allRed_q    <= 8'd0;
      flash_q     <= 9'd0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      hLamp_q     <= hLamp_d;
      cLamp_q     <= cLamp_d;
      prevH_q     <= prevH_d;
      prevC_q     <= prevC_d;
      prevValid_q <= prevValid_d;
      dwellH_q    <= dwellH_d;
      dwellC_q    <= dwellC_d;
      allRed_q    <= allRed_d;
      flash_q     <= flash_d;
    end
  end

  assign hwy_lamp   = hLamp_q;
  assign cntry_lamp = cLamp_q;
  assign fault      = (state_q == MON_FLASH);
  assign fault_code = code_q;

endmodule

// File: tb/tb_tlc_conflict_monitor.sv
// Bench for tlc_conflict_monitor: a default instance (A) and a short-interval instance (B)
// share the same inputs and are compared each edge against a rule-level model.
module tb_tlc_conflict_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] hwy = 2'b00;
  logic [1:0] cntry = 2'b00;
  logic       fault_clr = 1'b0;

  logic [1:0] hLampA, cLampA, hLampB, cLampB;
  logic       faultA, faultB;
  logic [2:0] codeA, codeB;

  int checks = 0;
  int errors = 0;

  tlc_conflict_monitor #(.MIN_GREEN(1), .MIN_YELLOW(1), .MIN_ALLRED(1), .FLASH_HALF(4)) dutA (
    .clk(clk), .reset(reset), .hwy(hwy), .cntry(cntry), .fault_clr(fault_clr),
    .hwy_lamp(hLampA), .cntry_lamp(cLampA), .fault(faultA), .fault_code(codeA)
  );

  tlc_conflict_monitor #(.MIN_GREEN(3), .MIN_YELLOW(1), .MIN_ALLRED(2), .FLASH_HALF(4)) dutB (
    .clk(clk), .reset(reset), .hwy(hwy), .cntry(cntry), .fault_clr(fault_clr),
    .hwy_lamp(hLampB), .cntry_lamp(cLampB), .fault(faultB), .fault_code(codeB)
  );

  always #5 clk = ~clk;

  // Reference model: one slot per instance, built from the monitoring rules.
  int mMinG[2]  = '{1, 3};
  int mMinY[2]  = '{1, 1};
  int mMinAR[2] = '{1, 2};
  int mHalf[2]  = '{4, 4};
  int mFault[2], mCode[2], mLampH[2], mLampC[2];
  int mValid[2], mPrevH[2], mPrevC[2], mRunH[2], mRunC[2], mAllRed[2], mSince[2];

  task automatic modelReset(input int k);
    mFault[k] = 0; mCode[k] = 0; mLampH[k] = 0; mLampC[k] = 0;
    mValid[k] = 0; mPrevH[k] = 0; mPrevC[k] = 0;
    mRunH[k] = 0; mRunC[k] = 0; mAllRed[k] = 0; mSince[k] = 0;
  endtask

  function automatic int roadCheck(input int k, input int oldC, input int newC, input int run);
    int successor[3] = '{2, 0, 1};
    int held, need;
    if (oldC == newC) return 0;
    if (newC != successor[oldC]) return 3;
    held = (oldC == 0) ? mAllRed[k] : run;
    if (held > 255) held = 255;
    need = (oldC == 2) ? mMinG[k] : (oldC == 1) ? mMinY[k] : mMinAR[k];
    if (held >= need) return 0;
    return (oldC == 2) ? 4 : (oldC == 1) ? 5 : 6;
  endfunction

  task automatic modelStep(input int k, input int h, input int c, input bit clr);
    int v, rv;
    if (mFault[k] != 0) begin
      if (clr) begin
        modelReset(k);
      end else begin
        mSince[k]++;
        mLampH[k] = ((mSince[k] % (2 * mHalf[k])) < mHalf[k]) ? 0 : 3;
        mLampC[k] = mLampH[k];
      end
      return;
    end
    v = 0;
    if (h == 3 || c == 3) v = 1;
    else if (h != 0 && c != 0) v = 2;
    else if (mValid[k] != 0) begin
      v = roadCheck(k, mPrevH[k], h, mRunH[k]);
      rv = roadCheck(k, mPrevC[k], c, mRunC[k]);
      if (rv != 0 && (v == 0 || rv < v)) v = rv;
    end
    if (v != 0) begin
      mFault[k] = 1; mCode[k] = v; mSince[k] = 0; mLampH[k] = 0; mLampC[k] = 0;
    end else begin
      mLampH[k] = h; mLampC[k] = c;
      mRunH[k] = (mValid[k] != 0 && h == mPrevH[k]) ? mRunH[k] + 1 : 1;
      mRunC[k] = (mValid[k] != 0 && c == mPrevC[k]) ? mRunC[k] + 1 : 1;
      mAllRed[k] = (h == 0 && c == 0) ? mAllRed[k] + 1 : 0;
      mPrevH[k] = h; mPrevC[k] = c; mValid[k] = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    chk("A hwy_lamp",   {6'd0, hLampA}, 8'(mLampH[0]));
    chk("A cntry_lamp", {6'd0, cLampA}, 8'(mLampC[0]));
    chk("A fault",      {7'd0, faultA}, 8'(mFault[0]));
    chk("A fault_code", {5'd0, codeA},  8'(mCode[0]));
    chk("B hwy_lamp",   {6'd0, hLampB}, 8'(mLampH[1]));
    chk("B cntry_lamp", {6'd0, cLampB}, 8'(mLampC[1]));
    chk("B fault",      {7'd0, faultB}, 8'(mFault[1]));
    chk("B fault_code", {5'd0, codeB},  8'(mCode[1]));
  endtask

  task automatic applyStimulus(input logic [1:0] h, input logic [1:0] c, input logic clr);
    hwy = h; cntry = c; fault_clr = clr;
    @(posedge clk);
    modelStep(0, int'(h), int'(c), clr);
    modelStep(1, int'(h), int'(c), clr);
    #1;
    checkOutput();
  endtask

  // Reset lands mid-cycle so its asynchronous effect is visible before any edge.
  task automatic doReset();
    #2 reset = 1'b1;
    #1;
    modelReset(0);
    modelReset(1);
    checkOutput();
    #1 reset = 1'b0;
  endtask

  initial begin
    int pH[6] = '{2, 1, 0, 0, 0, 0};
    int pC[6] = '{0, 0, 0, 2, 1, 0};
    int phase, remain;
    logic [1:0] h, c;

    modelReset(0);
    modelReset(1);
    #12;
    checkOutput();
    chk("reset lamps", {4'd0, hLampA, cLampA}, 8'h00);
    reset = 1'b0;

    $display("[TB] normal controller cycle");
    applyStimulus(2'b10, 2'b00, 1'b0);
    chk("first pass hwy", {6'd0, hLampA}, 8'h02);
    applyStimulus(2'b10, 2'b00, 1'b0);
    applyStimulus(2'b10, 2'b00, 1'b0);
    applyStimulus(2'b01, 2'b00, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b0);
    applyStimulus(2'b00, 2'b10, 1'b0);
    chk("B short clear code", {5'd0, codeB}, 8'd6);
    applyStimulus(2'b00, 2'b10, 1'b0);
    applyStimulus(2'b00, 2'b01, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b0);
    applyStimulus(2'b10, 2'b00, 1'b0);
    chk("A normal no fault", {7'd0, faultA}, 8'd0);

    $display("[TB] conflict and flash");
    doReset();
    applyStimulus(2'b10, 2'b00, 1'b0);
    applyStimulus(2'b10, 2'b10, 1'b0);
    chk("A conflict code", {5'd0, codeA}, 8'd2);
    chk("A conflict lamps", {4'd0, hLampA, cLampA}, 8'h00);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(2'b10, 2'b10, 1'b0);
      chk("A flash lamps", {4'd0, hLampA, cLampA}, ((i % 8) < 4) ? 8'h00 : 8'h0F);
    end

    $display("[TB] bad sequences");
    doReset();
    applyStimulus(2'b10, 2'b00, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b0);
    chk("A green to red code", {5'd0, codeA}, 8'd3);
    doReset();
    applyStimulus(2'b10, 2'b00, 1'b0);
    applyStimulus(2'b10, 2'b00, 1'b0);
    applyStimulus(2'b01, 2'b00, 1'b0);
    chk("B short green code", {5'd0, codeB}, 8'd4);
    applyStimulus(2'b10, 2'b00, 1'b0);
    chk("A yellow to green code", {5'd0, codeA}, 8'd3);

    $display("[TB] green held long enough");
    doReset();
    repeat (3) applyStimulus(2'b10, 2'b00, 1'b0);
    applyStimulus(2'b01, 2'b00, 1'b0);
    chk("B green held fault", {7'd0, faultB}, 8'd0);

    $display("[TB] priority, clear and mid-flash reset");
    doReset();
    applyStimulus(2'b11, 2'b10, 1'b0);
    chk("A priority code", {5'd0, codeA}, 8'd1);
    applyStimulus(2'b10, 2'b10, 1'b0);
    applyStimulus(2'b10, 2'b00, 1'b1);
    chk("A clear fault", {7'd0, faultA}, 8'd0);
    chk("A clear lamps", {4'd0, hLampA, cLampA}, 8'h00);
    applyStimulus(2'b10, 2'b00, 1'b0);
    chk("A after clear lamps", {4'd0, hLampA, cLampA}, 8'h08);
    applyStimulus(2'b10, 2'b10, 1'b0);
    repeat (5) applyStimulus(2'b00, 2'b00, 1'b0);
    doReset();
    chk("A mid-flash reset fault", {7'd0, faultA}, 8'd0);

    $display("[TB] randomized controller traffic");
    phase = 0;
    remain = 2;
    for (int n = 0; n < 2000; n++) begin
      if (remain == 0) begin
        phase = (phase + 1) % 6;
        remain = $urandom_range(1, 4);
      end
      remain--;
      h = 2'(pH[phase]);
      c = 2'(pC[phase]);
      if ($urandom_range(0, 24) == 0) begin
        h = 2'($urandom_range(0, 3));
        c = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 299) == 0) doReset();
      applyStimulus(h, c, ($urandom_range(0, 11) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
